// File: rtl/muldiv.sv
// muldiv: iterative MIPS MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO/MFHI/MFLO; fixed WIDTH+1 cycle latency.
// No backpressure: start while busy is dropped, so the controller stalls on busy. MULDIV_SIGNED_EN enables signed MULT/DIV.
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_opnd, r_hi, r_lo;
    logic               r_is_div, r_zero, r_done, r_div0;

    logic               w_go_mul, w_go_div, w_mthi, w_mtlo, w_accept;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_quo, w_rem;
    logic [WIDTH:0]     w_sum, w_shift, w_diff;
    logic [2*WIDTH-1:0] w_prod;

    assign w_go_mul = start && (funct[5:1] == 5'b01100);
    assign w_go_div = start && (funct[5:1] == 5'b01101);
    assign w_mthi   = start && (funct == 6'b010001);
    assign w_mtlo   = start && (funct == 6'b010011);
    assign w_accept = (r_state == S_IDLE) && (w_go_mul || w_go_div);

`ifdef MULDIV_SIGNED_EN
    logic w_a_neg, w_b_neg, r_neg_res, r_neg_rem;

    assign w_a_neg = ~funct[0] & a[WIDTH-1];
    assign w_b_neg = ~funct[0] & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (w_accept) begin
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
        end
    end

    // The remainder follows the dividend's sign; product and quotient follow the xor of signs.
    assign w_prod = r_neg_res ? -r_p : r_p;
    assign w_quo  = r_neg_res ? -r_p[WIDTH-1:0] : r_p[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? -r_p[2*WIDTH-1:WIDTH] : r_p[2*WIDTH-1:WIDTH];
`else
    assign w_a_mag = a;
    assign w_b_mag = b;
    assign w_prod  = r_p;
    assign w_quo   = r_p[WIDTH-1:0];
    assign w_rem   = r_p[2*WIDTH-1:WIDTH];
`endif

    // r_p upper half: product high / partial remainder; lower half: multiplier / dividend-then-quotient.
    assign w_sum   = r_p[0] ? ({1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd})
                            : {1'b0, r_p[2*WIDTH-1:WIDTH]};
    assign w_shift = r_p[2*WIDTH-1:WIDTH-1];
    assign w_diff  = w_shift - {1'b0, r_opnd};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go_mul)      w_next = S_MUL;
                else if (w_go_div) w_next = S_DIV;
            end
            S_MUL, S_DIV: if (r_cnt == LAST) w_next = S_FIX;
            S_FIX:        w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_p      <= '0;
            r_opnd   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_is_div <= 1'b0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mthi) r_hi <= a;
                    if (w_mtlo) r_lo <= a;
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_is_div <= w_go_div;
                        r_zero   <= (b == '0);
                        r_p      <= w_go_mul ? {{WIDTH{1'b0}}, w_b_mag} : {{WIDTH{1'b0}}, w_a_mag};
                        r_opnd   <= w_go_mul ? w_a_mag : w_b_mag;
                    end
                end
                S_MUL: begin
                    r_p   <= {w_sum, r_p[WIDTH-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV: begin
                    if (!w_diff[WIDTH]) r_p <= {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
                    else                r_p <= {w_shift[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_hi   <= w_rem;
                        r_lo   <= r_zero ? {WIDTH{1'b1}} : w_quo;
                        r_div0 <= r_zero;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign div0   = r_div0;
    assign result = funct[1] ? r_lo : r_hi;
endmodule

// File: doc/muldiv.md
# muldiv

Parametrised iterative multiply/divide unit with HI/LO registers. It extends the ALU control path with the MIPS MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO R-type functions. It sits beside the ALU in the execute stage. The datapath controller stalls on `busy` and reads `result` for MFHI/MFLO.

## Interface
- `WIDTH`, 32, operand width, ≥ 2; HI and LO are each `WIDTH` bits.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled at a rising edge together with `funct`, `a` and `b`.
- `funct`  in  6  R-type function field.
- `a`  in  WIDTH  rs operand: dividend, multiplicand, or MTHI/MTLO data.
- `b`  in  WIDTH  rt operand: divisor or multiplier.
- `busy`  out  1  multiply/divide in progress.
- `done`  out  1  one-cycle pulse; HI/LO hold a new multiply/divide result.
- `div0`  out  1  asserted with `done` when a divide had `b == 0`.
- `result`  out  WIDTH  combinational: `funct[1] ? LO : HI`.

## Operation
- Functions decoded:
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - Any other `funct` with `start` has no effect.
- States: IDLE, MUL, DIV, FIX. Reset enters IDLE.
- IDLE:
  - `start` & MTHI loads HI ← `a` at the edge.
  - `start` & MTLO loads LO ← `a` at the edge.
  - Neither sets `busy` or `done`.
- IDLE, `start` & MULT/MULTU:
  - Latch operands.
  - For signed ops, latch operand magnitudes and the product sign.
  - Go to MUL.
- MUL: one shift-add step per cycle for `WIDTH` cycles, then FIX.
- IDLE, `start` & DIV/DIVU:
  - Latch operands; for signed ops, latch magnitudes, quotient sign and dividend sign.
  - Go to DIV.
- DIV: one restoring subtract-shift step per cycle for `WIDTH` cycles, then FIX.
- FIX (one cycle):
  - Apply two's-complement sign correction.
  - Product: negated if the operand signs differ.
  - Quotient: negated if the signs differ.
  - Remainder: takes the dividend's sign.
  - At the end of FIX, write HI/LO, pulse `done` and return to IDLE.
- Product: HI = upper `WIDTH` bits, LO = lower `WIDTH` bits, full 2·WIDTH result.
- Divide: LO = quotient, HI = remainder.
- Divide by zero (signed or unsigned): LO = all ones, HI = `a` as presented; `div0` = 1 with `done`.
- Signed overflow (most-negative ÷ −1): LO = most-negative, HI = 0, `div0` = 0.
- `start` while `busy` (any `funct`, including MTHI/MTLO) is ignored. The controller must stall.
- MFHI/MFLO while `busy` returns the old HI/LO. The controller must stall.
- `start` in the same cycle as `done` is accepted normally, since the state is IDLE by then.
- Reset mid-operation:
  - Aborts the operation.
  - HI = LO = 0, `busy` = `done` = `div0` = 0.
  - No partial result is written.

## Timing
- Reset values: `busy` 0, `done` 0, `div0` 0, HI 0, LO 0, so `result` = 0.
- Multiply/divide accepted at edge k:
  - `busy` = 1 from after edge k to after edge k+WIDTH+1 (WIDTH+1 cycles).
  - HI/LO updated at edge k+WIDTH+1.
  - `busy` falls and `done` rises after edge k+WIDTH+1; `done` lasts one cycle.
- MTHI/MTLO at edge k: `result` shows the new value in cycle k+1.
- Latency is fixed and independent of operand values and of signedness.

## Configuration
- `MULDIV_SIGNED_EN` defined:
  - MULT/DIV are signed as described above.
- `MULDIV_SIGNED_EN` undefined:
  - MULT executes as MULTU and DIV as DIVU.
  - Sign-magnitude logic is removed.
  - FIX is a no-op cycle, so latency is unchanged.
  - Divide-by-zero and `div0` behaviour are unchanged.

## Test plan
- Reset asserted mid-cycle, asynchronously → immediately `busy` = `done` = `div0` = 0 and `result` = 0 for MFHI and MFLO.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF (WIDTH=32) → `busy` for 33 cycles, then `done` for one cycle; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD, b=7:
  - With macro → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - Without macro → HI=0x00000006, LO=0xFFFFFFEB.
- Signed divides (macro defined):
  - DIV a=0xFFFFFFF9, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0, `div0`=0.
- DIVU a=7, b=0 → LO=0xFFFFFFFF, HI=7, `div0`=1 only in the `done` cycle.
- MTLO 0x1234 while `busy` → ignored, LO is the divide result.
- MTHI 0xAAAA when idle → MFHI `result`=0xAAAA in the next cycle.
- Reset at MUL iteration 10 → HI=LO=0, no `done`; a following MULTU 3×5 gives LO=15, HI=0.
